// File: rtl/log_arbiter_pkg.sv
// Shared types and constants for the log arbiter: severity levels and field widths.
package log_arbiter_pkg;

    localparam int LEVEL_W    = 2;
    localparam int DROP_CNT_W = 16;

    typedef enum logic [LEVEL_W-1:0] {
        LVL_DEBUG   = 2'd0,
        LVL_INFO    = 2'd1,
        LVL_WARNING = 2'd2,
        LVL_ERROR   = 2'd3
    } log_level_e;

    // A record is forwarded when its severity reaches the runtime threshold.
    function automatic logic level_passes(input logic [LEVEL_W-1:0] lvl,
                                          input logic [LEVEL_W-1:0] thr);
        return (lvl >= thr);
    endfunction

endpackage

// File: rtl/log_arbiter_rr.sv
// Round-robin arbiter: picks the first eligible requester at or after the
// rotating pointer and moves the pointer just past every grant.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         i_eligible,
    output logic [N_REQ-1:0]         o_grant,
    output logic [$clog2(N_REQ)-1:0] o_index,
    output logic                     o_valid
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_index;
    logic             w_found;

    // Scan from the furthest position back to the pointer so the closest eligible one wins.
    always_comb begin
        w_sum   = '0;
        w_idx   = '0;
        w_index = '0;
        w_found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum   = {1'b0, r_ptr} + (IDX_W+1)'(k);
            w_sum   = (w_sum >= (IDX_W+1)'(N_REQ)) ? (w_sum - (IDX_W+1)'(N_REQ)) : w_sum;
            w_idx   = w_sum[IDX_W-1:0];
            w_index = i_eligible[w_idx] ? w_idx : w_index;
            w_found = w_found | i_eligible[w_idx];
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_index == IDX_W'(N_REQ - 1)) ? '0 : (w_index + IDX_W'(1));
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_grant = w_found ? (N_REQ'(1) << w_index) : '0;
    assign o_index = w_index;
    assign o_valid = w_found;

endmodule

// File: rtl/log_arbiter.sv
// Log arbiter: round-robin merge of N_REQ log streams with a severity filter.
// Optional drop counter enabled by defining LOG_ARBITER_DROP_COUNT_EN.
module log_arbiter
    import log_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16
) (
    input  logic                       CLK,
    input  logic                       ASYNCRESET,
    input  logic                       CE,
    input  logic [LEVEL_W-1:0]         min_level,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [LEVEL_W*N_REQ-1:0]   req_level,
    input  logic [DATA_W*N_REQ-1:0]    req_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(N_REQ)-1:0]   out_src,
    output logic [LEVEL_W-1:0]         out_level,
    output logic [DATA_W-1:0]          out_data,
    output logic [DROP_CNT_W-1:0]      drop_count
);
    localparam int IDX_W = $clog2(N_REQ);

    logic                r_out_valid;
    logic [IDX_W-1:0]    r_out_src;
    logic [LEVEL_W-1:0]  r_out_level;
    logic [DATA_W-1:0]   r_out_data;

    logic                w_slot_free;
    logic [N_REQ-1:0]    w_eligible;
    logic [N_REQ-1:0]    w_grant;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic                w_gnt_valid;
    logic [LEVEL_W-1:0]  w_gnt_level;
    logic [DATA_W-1:0]   w_gnt_data;
    logic                w_fwd;

    assign w_slot_free = !r_out_valid || out_ready;

    // Records below threshold may always be taken (they are dropped); others need a free slot.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_eligible[i] = req_valid[i] && CE && !ASYNCRESET &&
                            (!level_passes(req_level[LEVEL_W*i +: LEVEL_W], min_level) || w_slot_free);
        end
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk        (CLK),
        .rst        (ASYNCRESET),
        .i_eligible (w_eligible),
        .o_grant    (w_grant),
        .o_index    (w_gnt_idx),
        .o_valid    (w_gnt_valid)
    );

    // Route the granted requester's level and payload.
    always_comb begin
        w_gnt_level = '0;
        w_gnt_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_gnt_level = w_grant[i] ? req_level[LEVEL_W*i +: LEVEL_W] : w_gnt_level;
            w_gnt_data  = w_grant[i] ? req_data[DATA_W*i +: DATA_W]    : w_gnt_data;
        end
    end

    assign w_fwd = w_gnt_valid && level_passes(w_gnt_level, min_level);

    // Output register; a forwarding grant implies the slot is free, so it never overwrites a held record.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_out_level <= LVL_DEBUG;
            r_out_data  <= '0;
        end else if (w_fwd) begin
            r_out_valid <= 1'b1;
            r_out_src   <= w_gnt_idx;
            r_out_level <= w_gnt_level;
            r_out_data  <= w_gnt_data;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

`ifdef LOG_ARBITER_DROP_COUNT_EN
    logic                  w_drop;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    assign w_drop = w_gnt_valid && !level_passes(w_gnt_level, min_level);

    // Saturating count of filtered records.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign drop_count = r_drop_cnt;
`else
    assign drop_count = '0;
`endif

    assign req_ready = w_grant;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;
    assign out_level = r_out_level;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_log_arbiter.sv
// Directed self-checking bench for log_arbiter (N_REQ=4, DATA_W=16); expected
// drop counts follow LOG_ARBITER_DROP_COUNT_EN.
module tb_log_arbiter;

    logic        CLK;
    logic        ASYNCRESET;
    logic        CE;
    logic [1:0]  min_level;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_level;
    logic [63:0] req_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_src;
    logic [1:0]  out_level;
    logic [15:0] out_data;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    log_arbiter #(.N_REQ(4), .DATA_W(16)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .CE         (CE),
        .min_level  (min_level),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_level  (req_level),
        .req_data   (req_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_src    (out_src),
        .out_level  (out_level),
        .out_data   (out_data),
        .drop_count (drop_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_drop(input int n);
`ifdef LOG_ARBITER_DROP_COUNT_EN
        return (n > 65535) ? 32'hFFFF : 32'(n);
`else
        return 32'(n) & 32'h0;
`endif
    endfunction

    task automatic set_req(input int i, input logic v, input logic [1:0] lv, input logic [15:0] d);
        req_valid[i]         = v;
        req_level[2*i +: 2]  = lv;
        req_data[16*i +: 16] = d;
    endtask

    initial begin
        ASYNCRESET = 1'b1;
        CE         = 1'b0;
        min_level  = 2'd0;
        req_valid  = 4'b0000;
        req_level  = 8'h00;
        req_data   = 64'h0;
        out_ready  = 1'b0;
        #3;
        check("rst_valid", out_valid, 32'd0);
        check("rst_ready", req_ready, 32'd0);
        check("rst_data",  out_data,  32'd0);
        check("rst_drop",  drop_count, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        ASYNCRESET = 1'b0;

        // Round-robin sweep with every requester valid.
        CE        = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'd2, 16'hA000 + 16'(i));
        for (int c = 0; c < 5; c++) begin
            #1;
            check("rr_ready", req_ready, 32'd1 << (c % 4));
            @(negedge CLK);
            check("rr_src",   out_src,   32'(c % 4));
            check("rr_data",  out_data,  32'hA000 + 32'(c % 4));
            check("rr_valid", out_valid, 32'd1);
        end
        req_valid = 4'b0000;
        @(negedge CLK);
        check("drain_valid", out_valid, 32'd0);

        // Backpressure: pointer is 1; load req 2 and hold it for 5 cycles.
        out_ready = 1'b0;
        set_req(2, 1'b1, 2'd3, 16'hC0DE);
        #1;
        check("bp_first_ready", req_ready, 32'b0100);
        @(negedge CLK);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_ready", req_ready, 32'd0);
            @(negedge CLK);
            check("bp_valid", out_valid, 32'd1);
            check("bp_data",  out_data,  32'hC0DE);
        end
        out_ready = 1'b1;
        set_req(2, 1'b1, 2'd3, 16'hC0DF);
        #1;
        check("bp_reload_ready", req_ready, 32'b0100);
        @(negedge CLK);
        check("bp_reload_data",  out_data,  32'hC0DF);
        check("bp_reload_valid", out_valid, 32'd1);
        req_valid = 4'b0000;
        @(negedge CLK);
        check("bp_drain", out_valid, 32'd0);

        // Drop while output held; pointer is 3 so req 0 loads first.
        out_ready = 1'b0;
        set_req(0, 1'b1, 2'd3, 16'h1111);
        @(negedge CLK);
        req_valid = 4'b0000;
        set_req(1, 1'b1, 2'd1, 16'h2222);
        min_level = 2'd1;
        #1;
        check("thr_block", req_ready, 32'd0);
        min_level = 2'd2;
        #1;
        check("thr_same_cycle", req_ready, 32'b0010);
        @(negedge CLK);
        check("drop_cnt1",   drop_count, exp_drop(1));
        check("drop_src",    out_src,    32'd0);
        check("drop_level",  out_level,  32'd3);
        check("drop_data",   out_data,   32'h1111);
        check("drop_valid",  out_valid,  32'd1);
        req_valid = 4'b0000;
        min_level = 2'd0;
        out_ready = 1'b1;
        @(negedge CLK);
        check("drop_drain", out_valid, 32'd0);

        // Clock enable low: pointer is 2 and must be kept.
        CE = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'd2, 16'hB000 + 16'(i));
        for (int c = 0; c < 3; c++) begin
            #1;
            check("ce_ready", req_ready, 32'd0);
            @(negedge CLK);
            check("ce_valid", out_valid, 32'd0);
        end
        check("ce_drop", drop_count, exp_drop(1));
        CE = 1'b1;
        #1;
        check("ce_resume_ready", req_ready, 32'b0100);
        @(negedge CLK);
        check("ce_resume_src",  out_src,  32'd2);
        check("ce_resume_data", out_data, 32'hB002);

        // Mid-cycle reset with a record held.
        req_valid = 4'b0000;
        out_ready = 1'b0;
        check("pre_rst_valid", out_valid, 32'd1);
        #1;
        ASYNCRESET = 1'b1;
        #1;
        check("arst_valid", out_valid, 32'd0);
        check("arst_data",  out_data,  32'd0);
        check("arst_drop",  drop_count, 32'd0);
        ASYNCRESET = 1'b0;
        req_valid  = 4'b1111;
        out_ready  = 1'b1;
        #1;
        check("arst_next_ready", req_ready, 32'b0001);
        @(negedge CLK);
        check("arst_next_src", out_src, 32'd0);
        req_valid = 4'b0000;
        @(negedge CLK);

        // Saturation of the drop counter.
        min_level = 2'd3;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 2'd0, 16'hD000);
        repeat (3) @(negedge CLK);
        check("sat_cnt3", drop_count, exp_drop(3));
`ifdef LOG_ARBITER_DROP_COUNT_EN
        repeat (65537) @(negedge CLK);
        check("sat_full", drop_count, exp_drop(65540));
`else
        repeat (20) @(negedge CLK);
        check("sat_tied", drop_count, exp_drop(23));
`endif
        check("sat_no_fwd", out_valid, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
